// File: rtl/spi_instruction_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_instruction_receiver_if
//  Description : SPI pins plus execution-unit instruction hand-off signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_instruction_receiver_if #(
    parameter int INPUT_DATA_WIDTH  = 4,
    parameter int OUTPUT_DATA_WIDTH = 8
);
    logic                            spi_sclk;
    logic                            spi_cs_n;
    logic                            spi_mosi;
    logic                            spi_miso;
    logic [OUTPUT_DATA_WIDTH-1:0]    result_in;
    logic [INPUT_DATA_WIDTH-1:0]     opcode;
    logic [2*INPUT_DATA_WIDTH-1:0]   operand;
    logic                            start;
    logic                            frame_err;

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, result_in,
        input  spi_miso, opcode, operand, start, frame_err
    );

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, result_in,
        output spi_miso, opcode, operand, start, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_instruction_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : spi_instruction_receiver
//  Description : SPI mode-0 slave receiving {opcode, operand} frames, with
//                frame-length check and optional MISO result readback
//                (enabled by defining SPI_READBACK_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_instruction_receiver #(
    parameter int INPUT_DATA_WIDTH  = 4,
    parameter int OUTPUT_DATA_WIDTH = 8,
    parameter int SYNC_STAGES       = 2
) (
    input wire clk,
    input wire reset,
    spi_instruction_receiver_if.slave bus
);
    localparam int c_OPERAND_W = 2 * INPUT_DATA_WIDTH;
    localparam int c_FRAME_W   = 3 * INPUT_DATA_WIDTH;
    localparam int c_CNT_W     = $clog2(c_FRAME_W + 1);
    localparam int c_FLUSH_W   = $clog2(SYNC_STAGES + 2);

    localparam logic [c_CNT_W-1:0]   c_FULL_CNT   = c_CNT_W'(c_FRAME_W);
    localparam logic [c_CNT_W-1:0]   c_LAST_CNT   = c_CNT_W'(c_FRAME_W - 1);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_DONE = c_FLUSH_W'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [SYNC_STAGES-1:0]   r_sclk_sync;
    logic [SYNC_STAGES-1:0]   r_cs_n_sync;
    logic [SYNC_STAGES-1:0]   r_mosi_sync;
    logic                     r_sclk_prev;
    logic                     r_cs_n_prev;
    logic [c_FLUSH_W-1:0]     r_flush_cnt;

    logic                     w_sync_valid;
    logic                     w_sclk_s;
    logic                     w_cs_n_s;
    logic                     w_mosi_s;
    logic                     w_sclk_rise;
    logic                     w_cs_fall;
    logic                     w_cs_rise;

    logic [c_FRAME_W-1:0]     r_shift;
    logic [c_CNT_W-1:0]       r_bit_cnt;
    logic                     r_overrun;
    logic [INPUT_DATA_WIDTH-1:0] r_opcode;
    logic [c_OPERAND_W-1:0]   r_operand;
    logic                     r_start;
    logic                     r_frame_err;

    logic                     w_frame_open;
    logic                     w_shift_in;
    logic                     w_overrun_set;
    logic                     w_commit;
    logic                     w_drop;

    // Synchronisers reset to the bus idle levels. Edges are ignored until the
    // chains have refilled from the pins, so a cs_n held low across reset never
    // looks like a fresh frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_cs_n_sync <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_n_prev <= 1'b1;
            r_flush_cnt <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            r_cs_n_sync <= {r_cs_n_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            r_sclk_prev <= w_sclk_s;
            r_cs_n_prev <= w_cs_n_s;
            if (!w_sync_valid) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign w_sync_valid = (r_flush_cnt == c_FLUSH_DONE);
    assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n_s     = r_cs_n_sync[SYNC_STAGES-1];
    assign w_mosi_s     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise  = w_sync_valid &  w_sclk_s & ~r_sclk_prev;
    assign w_cs_fall    = w_sync_valid & ~w_cs_n_s &  r_cs_n_prev;
    assign w_cs_rise    = w_sync_valid &  w_cs_n_s & ~r_cs_n_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // cs_n release takes priority over any sclk edge seen in the same cycle.
    always_comb begin
        w_state_next  = r_state;
        w_frame_open  = 1'b0;
        w_shift_in    = 1'b0;
        w_overrun_set = 1'b0;
        w_commit      = 1'b0;
        w_drop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_frame_open = 1'b1;
                    w_state_next = S_RECV;
                end
            end
            S_RECV, S_FULL: begin
                if (w_cs_rise) begin
                    w_state_next = S_IDLE;
                    if ((r_bit_cnt == c_FULL_CNT) && !r_overrun) begin
                        w_commit = 1'b1;
                    end else if (r_bit_cnt != '0) begin
                        w_drop = 1'b1;
                    end
                end else if (w_sclk_rise) begin
                    if (r_state == S_RECV) begin
                        w_shift_in = 1'b1;
                        if (r_bit_cnt == c_LAST_CNT) begin
                            w_state_next = S_FULL;
                        end
                    end else begin
                        w_overrun_set = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_overrun   <= 1'b0;
            r_opcode    <= '0;
            r_operand   <= '0;
            r_start     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_start     <= w_commit;
            r_frame_err <= w_drop;
            if (w_commit) begin
                r_opcode  <= r_shift[c_FRAME_W-1 -: INPUT_DATA_WIDTH];
                r_operand <= r_shift[c_OPERAND_W-1:0];
            end
            if (w_frame_open) begin
                r_bit_cnt <= '0;
                r_overrun <= 1'b0;
            end
            if (w_shift_in) begin
                r_shift   <= {r_shift[c_FRAME_W-2:0], w_mosi_s};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.opcode    = r_opcode;
    assign bus.operand   = r_operand;
    assign bus.start     = r_start;
    assign bus.frame_err = r_frame_err;

`ifdef SPI_READBACK_EN
    logic [OUTPUT_DATA_WIDTH-1:0] r_miso_sr;
    logic                         r_miso;
    logic                         w_sclk_fall;

    assign w_sclk_fall = w_sync_valid & ~w_sclk_s & r_sclk_prev;

    // The result byte is latched at frame start; MSB leads so the master sees
    // it on the first sclk rise, later bits follow each sclk fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_miso_sr <= '0;
            r_miso    <= 1'b0;
        end else if (w_frame_open) begin
            r_miso_sr <= bus.result_in;
            r_miso    <= bus.result_in[OUTPUT_DATA_WIDTH-1];
        end else if (w_state_next == S_IDLE) begin
            r_miso_sr <= '0;
            r_miso    <= 1'b0;
        end else if (w_sclk_fall) begin
            r_miso_sr <= {r_miso_sr[OUTPUT_DATA_WIDTH-2:0], 1'b0};
            r_miso    <= r_miso_sr[OUTPUT_DATA_WIDTH-2];
        end
    end

    assign bus.spi_miso = r_miso;
`else
    logic w_unused_result;

    assign w_unused_result = ^bus.result_in;
    assign bus.spi_miso    = 1'b0;
`endif

endmodule
`default_nettype wire
